// File: rtl/quad_enc_pkg.sv
`default_nettype none
// ============================================================================
// quad_enc_pkg
//   Shared quadrature step codes, transition lookup and default velocity window.
//   Revision: 1.0
// ============================================================================
package quad_enc_pkg;

  localparam int VEL_PERIOD_DEFAULT = 100000;

  localparam logic [1:0] STEP_NONE    = 2'd0;
  localparam logic [1:0] STEP_FWD     = 2'd1;
  localparam logic [1:0] STEP_REV     = 2'd2;
  localparam logic [1:0] STEP_ILLEGAL = 2'd3;

  // Forward Gray order is 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] step_lookup(input logic [1:0] prev_ab,
                                             input logic [1:0] cur_ab);
    logic [1:0] code;
    case ({prev_ab, cur_ab})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: code = STEP_FWD;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: code = STEP_REV;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: code = STEP_ILLEGAL;
      default:                            code = STEP_NONE;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/quad_step_lut.sv
`default_nettype none
// ============================================================================
// quad_step_lut
//   Combinational previous/current A-B pair to step code and illegal flag.
//   Revision: 1.0
// ============================================================================
module quad_step_lut
  import quad_enc_pkg::*;
(
  input  logic [1:0] i_prev_ab,
  input  logic [1:0] i_cur_ab,
  output logic [1:0] o_step_code,
  output logic       o_illegal
);

  assign o_step_code = step_lookup(i_prev_ab, i_cur_ab);
  assign o_illegal   = (o_step_code == STEP_ILLEGAL);

endmodule
`default_nettype wire

// File: rtl/quad_decode_vel.sv
`default_nettype none
// ============================================================================
// quad_decode_vel
//   Quadrature decoder with wrapping position count and windowed velocity.
//   Revision: 1.0
// ============================================================================
module quad_decode_vel
  import quad_enc_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int VEL_W      = 16,
  parameter int VEL_PERIOD = VEL_PERIOD_DEFAULT
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    enable,
  input  logic                    in_a,
  input  logic                    in_b,
  input  logic                    invert,
  input  logic                    cnt_clr,
  input  logic                    err_clr,
  output logic [CNT_W-1:0]        count,
  output logic                    dir,
  output logic signed [VEL_W-1:0] velocity,
  output logic                    vel_valid,
  output logic                    err,
  output logic [7:0]              err_cnt
);

  localparam int                    TMR_W        = $clog2(VEL_PERIOD);
  localparam logic [TMR_W-1:0]      c_tmr_reload = TMR_W'(VEL_PERIOD - 1);
  localparam logic signed [VEL_W-1:0] c_vel_max  = {1'b0, {(VEL_W-1){1'b1}}};
  localparam logic signed [VEL_W-1:0] c_vel_min  = {1'b1, {(VEL_W-1){1'b0}}};

  logic [1:0]              r_prev_ab;
  logic                    r_primed;
  logic [CNT_W-1:0]        r_count;
  logic                    r_dir;
  logic                    r_err;
  logic [7:0]              r_err_cnt;
  logic [TMR_W-1:0]        r_timer;
  logic signed [VEL_W-1:0] r_acc;
  logic signed [VEL_W-1:0] r_velocity;
  logic                    r_vel_valid;

  logic [1:0]              w_cur_ab;
  logic [1:0]              w_step_code;
  logic                    w_illegal;
  logic                    w_active;
  logic                    w_illegal_act;
  logic [1:0]              w_step_raw;
  logic [1:0]              w_step;
  logic [VEL_W:0]          w_acc_sum;
  logic signed [VEL_W-1:0] w_acc_sat;

  assign w_cur_ab = {in_a, in_b};

  quad_step_lut u_step_lut (
    .i_prev_ab   (r_prev_ab),
    .i_cur_ab    (w_cur_ab),
    .o_step_code (w_step_code),
    .o_illegal   (w_illegal)
  );

  // Decoding waits one cycle after reset so the 00 reset value of prev_ab is never decoded.
  assign w_active      = r_primed & enable;
  assign w_illegal_act = w_illegal & w_active;

  always_comb begin
    w_step_raw = 2'b00;
    if (w_active) begin
      if (w_step_code == STEP_FWD) w_step_raw = 2'b01;
      else if (w_step_code == STEP_REV) w_step_raw = 2'b11;
    end
  end

  assign w_step    = invert ? (~w_step_raw + 2'd1) : w_step_raw;
  assign w_acc_sum = {r_acc[VEL_W-1], r_acc} + {{(VEL_W-1){w_step[1]}}, w_step};

  always_comb begin
    w_acc_sat = w_acc_sum[VEL_W-1:0];
    if (w_acc_sum[VEL_W] != w_acc_sum[VEL_W-1]) begin
      w_acc_sat = w_acc_sum[VEL_W] ? c_vel_min : c_vel_max;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_prev_ab <= 2'b00;
      r_primed  <= 1'b0;
      r_count   <= '0;
      r_dir     <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      r_prev_ab <= w_cur_ab;
      r_primed  <= 1'b1;
      if (cnt_clr) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + {{(CNT_W-2){w_step[1]}}, w_step};
      end
      if (w_step != 2'b00) begin
        r_dir <= ~w_step[1];
      end
      if (err_clr) begin
        r_err     <= w_illegal_act;
        r_err_cnt <= {7'd0, w_illegal_act};
      end else if (w_illegal_act) begin
        r_err <= 1'b1;
        if (r_err_cnt != 8'hFF) begin
          r_err_cnt <= r_err_cnt + 8'd1;
        end
      end
    end
  end

  // vel_valid is registered so the pulse coincides with the new velocity value.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_timer     <= c_tmr_reload;
      r_acc       <= '0;
      r_velocity  <= '0;
      r_vel_valid <= 1'b0;
    end else if (!enable) begin
      r_timer     <= c_tmr_reload;
      r_acc       <= '0;
      r_vel_valid <= 1'b0;
    end else if (r_timer == '0) begin
      r_timer     <= c_tmr_reload;
      r_acc       <= '0;
      r_velocity  <= w_acc_sat;
      r_vel_valid <= 1'b1;
    end else begin
      r_timer     <= r_timer - 1'b1;
      r_acc       <= w_acc_sat;
      r_vel_valid <= 1'b0;
    end
  end

  assign count     = r_count;
  assign dir       = r_dir;
  assign velocity  = r_velocity;
  assign vel_valid = r_vel_valid;
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_quad_decode_vel.sv
`default_nettype none
// ============================================================================
// tb_quad_decode_vel
//   Directed plus random stimulus against a phase-arithmetic reference model.
//   Revision: 1.0
// ============================================================================
module tb_quad_decode_vel;

  localparam int P = 100;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        enable;
  logic        in_a;
  logic        in_b;
  logic        invert;
  logic        cnt_clr;
  logic        err_clr;
  logic [31:0] count;
  logic        dir;
  logic [15:0] velocity;
  logic        vel_valid;
  logic        err;
  logic [7:0]  err_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int phase;

  logic [31:0] m_count;
  logic        m_dir;
  logic        m_err;
  int          m_err_cnt;
  int          m_vel;
  logic        m_vv;
  int          m_win;
  int          m_acc;
  logic [1:0]  m_prev;
  logic        m_primed;

  always #5 pclk = ~pclk;

  quad_decode_vel #(
    .CNT_W      (32),
    .VEL_W      (16),
    .VEL_PERIOD (P)
  ) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .enable    (enable),
    .in_a      (in_a),
    .in_b      (in_b),
    .invert    (invert),
    .cnt_clr   (cnt_clr),
    .err_clr   (err_clr),
    .count     (count),
    .dir       (dir),
    .velocity  (velocity),
    .vel_valid (vel_valid),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  function automatic int ph(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gray(input int p);
    case (p & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_dir = 0; m_err = 0; m_err_cnt = 0; m_vel = 0; m_vv = 0;
    m_win = 0; m_acc = 0; m_prev = 2'b00; m_primed = 0;
  endtask

  task automatic check_all();
    chk("count", count, m_count);
    chk("dir", 32'(dir), 32'(m_dir));
    chk("err", 32'(err), 32'(m_err));
    chk("err_cnt", 32'(err_cnt), 32'(m_err_cnt));
    chk("vel_valid", 32'(vel_valid), 32'(m_vv));
    chk("velocity", 32'($signed(velocity)), 32'(m_vel));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_count"}, count, 32'd0);
    chk({tag, "_dir"}, 32'(dir), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    chk({tag, "_vel_valid"}, 32'(vel_valid), 32'd0);
    chk({tag, "_velocity"}, 32'(velocity), 32'd0);
  endtask

  // One clock: model the edge from the inputs the DUT sampled, then compare everything.
  task automatic tick();
    int         d;
    int         st;
    logic       ill;
    logic [1:0] cur;
    @(posedge pclk);
    cur = {in_a, in_b};
    st  = 0;
    ill = 1'b0;
    if (m_primed && enable) begin
      d   = (ph(cur) - ph(m_prev) + 4) % 4;
      st  = (d == 1) ? 1 : ((d == 3) ? -1 : 0);
      ill = (d == 2);
      if (invert) st = -st;
    end
    if (cnt_clr) m_count = 0;
    else         m_count = m_count + 32'(st);
    if (st != 0) m_dir = (st > 0);
    if (err_clr) begin
      m_err     = ill;
      m_err_cnt = ill ? 1 : 0;
    end else if (ill) begin
      m_err     = 1'b1;
      m_err_cnt = (m_err_cnt < 255) ? m_err_cnt + 1 : 255;
    end
    if (!enable) begin
      m_win = 0; m_acc = 0; m_vv = 0;
    end else begin
      m_win++;
      m_acc = m_acc + st;
      if (m_acc > 32767)  m_acc = 32767;
      if (m_acc < -32768) m_acc = -32768;
      if (m_win == P) begin
        m_vel = m_acc; m_vv = 1; m_win = 0; m_acc = 0;
      end else begin
        m_vv = 0;
      end
    end
    m_prev   = cur;
    m_primed = 1'b1;
    #1;
    check_all();
  endtask

  task automatic step_ab(input int dlt);
    phase = (phase + dlt + 8) & 3;
    {in_a, in_b} = gray(phase);
  endtask

  task automatic wait_vel(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!vel_valid && n < 250);
    chk("vel_pulse_seen", 32'(vel_valid), 32'd1);
  endtask

  initial begin
    int          n;
    logic [31:0] saved;

    presetn = 0; enable = 1; in_a = 1; in_b = 1; invert = 0; cnt_clr = 0; err_clr = 0;
    phase = 2;
    model_reset();
    #2;
    check_zero("reset");
    @(negedge pclk);
    presetn = 1;
    repeat (5) tick();
    chk("prime_count", count, 32'd0);
    chk("prime_err", 32'(err), 32'd0);

    for (int i = 0; i < 8; i++) begin step_ab(1); repeat (4) tick(); end
    chk("fwd8_count", count, 32'd8);
    chk("fwd8_dir", 32'(dir), 32'd1);
    for (int i = 0; i < 10; i++) begin step_ab(-1); repeat (4) tick(); end
    chk("rev10_count", count, 32'hFFFF_FFFE);
    chk("rev10_dir", 32'(dir), 32'd0);

    cnt_clr = 1; tick(); cnt_clr = 0;
    chk("clr_count", count, 32'd0);
    invert = 1;
    for (int i = 0; i < 4; i++) begin step_ab(1); repeat (2) tick(); end
    chk("inv_count", count, 32'hFFFF_FFFC);
    step_ab(2); tick();
    chk("illegal_count", count, 32'hFFFF_FFFC);
    chk("illegal_err", 32'(err), 32'd1);
    chk("illegal_err_cnt", 32'(err_cnt), 32'd1);
    err_clr = 1; tick(); err_clr = 0;
    chk("err_clr_err", 32'(err), 32'd0);
    chk("err_clr_cnt", 32'(err_cnt), 32'd0);
    invert = 0;

    enable = 0; tick(); enable = 1;
    for (int i = 0; i < 20; i++) begin step_ab(1); repeat (4) tick(); end
    wait_vel(n);
    chk("vel20_cycle", 32'(80 + n), 32'd100);
    chk("vel20_value", 32'($signed(velocity)), 32'd20);
    wait_vel(n);
    chk("vel0_cycle", 32'(n), 32'd100);
    chk("vel0_value", 32'($signed(velocity)), 32'd0);

    enable = 0; tick(); enable = 1;
    step_ab(1); cnt_clr = 1; tick(); cnt_clr = 0;
    chk("clr_step_count", count, 32'd0);
    wait_vel(n);
    chk("clr_step_vel", 32'($signed(velocity)), 32'd1);

    repeat (300) begin step_ab(2); tick(); end
    chk("err_sat", 32'(err_cnt), 32'd255);
    err_clr = 1; tick(); err_clr = 0;

    saved = m_count;
    enable = 0;
    for (int i = 0; i < 50; i++) begin
      if (i % 5 == 0) step_ab(1);
      tick();
    end
    enable = 1;
    repeat (5) tick();
    chk("en_hold_count", count, saved);

    repeat (1500) begin
      {in_a, in_b} = 2'($urandom);
      enable  = ($urandom % 16) != 0;
      if ($urandom % 64 == 0) invert = ~invert;
      cnt_clr = ($urandom % 32) == 0;
      err_clr = ($urandom % 32) == 0;
      tick();
    end

    enable = 1; invert = 0; cnt_clr = 0; err_clr = 0;
    phase = ph({in_a, in_b});
    for (int i = 0; i < 10; i++) begin step_ab(1); repeat (3) tick(); end
    presetn = 0;
    #1;
    check_zero("mid_reset");
    model_reset();
    @(negedge pclk);
    presetn = 1;
    for (int i = 0; i < 6; i++) begin step_ab(-1); repeat (3) tick(); end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/quad_decode_vel.md
Name: quad_decode_vel

Overview:
- Quadrature decoder core with position counter and windowed velocity measurement.
- Sits directly downstream of the per-channel debounce stage; consumes one debounced A/B pair.
- Feeds the APB register block, one instance per encoder channel.
- Adds direction, illegal-transition detection and a fixed-period velocity sample to the raw position count.

Parameters:
- CNT_W, 32, position counter width in bits; wraps modulo 2^CNT_W.
- VEL_W, 16, signed velocity width in bits.
- VEL_PERIOD, 100000, velocity window length in pclk cycles; must be at least 2.

Ports:
- pclk  in  1  clock.
- presetn  in  1  reset; asynchronous, active-low.
- enable  in  1  decoding and velocity timing enabled when high.
- in_a  in  1  debounced encoder channel A, already synchronous to pclk.
- in_b  in  1  debounced encoder channel B, already synchronous to pclk.
- invert  in  1  swaps the sign of every step.
- cnt_clr  in  1  synchronous single-cycle clear of the position count.
- err_clr  in  1  synchronous clear of the error flag and error count.
- count  out  CNT_W  position count, two's complement.
- dir  out  1  direction of the last valid step; 1 = forward.
- velocity  out  VEL_W  signed step total over the last completed window.
- vel_valid  out  1  one-cycle pulse when velocity updates.
- err  out  1  sticky illegal-transition flag.
- err_cnt  out  8  saturating illegal-transition count.

Behaviour:
- Reset (async assert, sync release): all outputs 0; prev_ab 00; primed 0; window timer at VEL_PERIOD-1; accumulator 0.
- Sampling:
  - cur_ab = {in_a, in_b} is sampled every pclk, whether or not enable is high.
  - prev_ab <= cur_ab every cycle.
  - The first cycle after reset only loads prev_ab and sets primed; no decode happens on that cycle.
- Decode (when primed and enable): Gray sequence 00→01→11→10→00 is a forward step (+1); the reverse sequence is −1.
  - No change: step = 0.
  - Both bits change (00↔11, 01↔10): illegal; step = 0; err <= 1; err_cnt increments, saturating at 255.
  - invert = 1 negates the step.
- Count update:
  - count <= count + step, wrapping modulo 2^CNT_W (0 − 1 gives all ones).
  - Latency: count reflects an edge on in_a/in_b one pclk after the edge is presented.
  - dir updates only on a nonzero step.
- cnt_clr:
  - count <= 0 and overrides any step in the same cycle.
  - That step is discarded from count but still accumulated into velocity.
- err_clr:
  - err and err_cnt <= 0.
  - If an illegal transition occurs in the same cycle, err = 1 and err_cnt = 1.
- Velocity window:
  - The timer counts down from VEL_PERIOD-1 while enable is high.
  - acc accumulates step each cycle, saturating at the signed VEL_W limits.
  - Cycle with timer = 0: velocity <= sat(acc + step); vel_valid = 1 for that cycle; acc <= 0; timer reloads to VEL_PERIOD-1.
- enable low:
  - count, dir and err hold.
  - Timer reloads to VEL_PERIOD-1; acc <= 0; vel_valid = 0; velocity holds.
  - prev_ab keeps tracking, so re-enabling produces no spurious step.
- Reset asserted mid-window: everything returns to reset values immediately, and the primed sequence repeats after release.

Decomposition:
- Shared package (quad_enc_pkg) holds:
  - step encoding constants STEP_NONE / STEP_FWD / STEP_REV / STEP_ILLEGAL;
  - the 4x4 transition lookup function;
  - the default VEL_PERIOD.
- One natural sub-module, quad_step_lut: combinational prev_ab/cur_ab → step code and illegal flag.
- The counters, timer and saturation logic stay in quad_decode_vel.

Test Plan:
- Reset with in_a/in_b = 11, release, hold 11 for 5 cycles → count = 0, err = 0; no step on the priming cycle.
- 8 forward Gray steps (00,01,11,10,...) spaced 4 cycles apart → count = 8, dir = 1; then 10 reverse steps → count = 0xFFFFFFFE, dir = 0.
- invert = 1, 4 forward steps from count = 0 → count = 0xFFFFFFFC; illegal jump 00→11 → count unchanged, err = 1, err_cnt = 1; err_clr → both 0.
- VEL_PERIOD = 100, 20 forward steps inside one window → vel_valid pulses once at cycle 100 with velocity = 20; the next quiet window gives velocity = 0.
- cnt_clr in the same cycle as a forward step → count = 0; that window's velocity still includes the step; 300 illegal transitions → err_cnt = 255.
- enable low for 50 cycles while A/B toggle 10 times, then enable high → count unchanged, no step on re-enable; asserting presetn low mid-window → all outputs 0 immediately.
